// File: rtl/lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store replication, misalignment and load extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_funct3_i,
  input  logic [1:0]  st_addr_lo_i,
  input  logic [31:0] st_wdata_i,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_addr_lo_i,
  input  logic [31:0] ld_rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misaligned_o,
  output logic [31:0] ld_data_o
);

  logic [31:0] ld_shifted;

  // Move the addressed lane down to bit 0 before extension.
  assign ld_shifted = ld_rdata_i >> {ld_addr_lo_i, 3'b000};

  always_comb begin
    be_o         = 4'b1111;
    wdata_o      = st_wdata_i;
    misaligned_o = 1'b0;
    case (st_funct3_i)
      F3_B, F3_BU: begin
        be_o    = 4'b0001 << st_addr_lo_i;
        wdata_o = {4{st_wdata_i[7:0]}};
      end
      F3_H, F3_HU: begin
        be_o         = 4'b0011 << st_addr_lo_i;
        wdata_o      = {2{st_wdata_i[15:0]}};
        misaligned_o = st_addr_lo_i[0];
      end
      default: misaligned_o = (st_addr_lo_i != 2'b00);
    endcase
  end

  always_comb begin
    ld_data_o = ld_shifted;
    case (ld_funct3_i)
      F3_B:    ld_data_o = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      F3_BU:   ld_data_o = {24'b0, ld_shifted[7:0]};
      F3_H:    ld_data_o = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      F3_HU:   ld_data_o = {16'b0, ld_shifted[15:0]};
      default: ld_data_o = ld_shifted;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one valid/ready bus transaction per memory instruction.
// Optional watchdog enabled by defining MEM_LSU_TIMEOUT_EN (adds Timeout_out).
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       ALUResult_in,
  input  logic [31:0]       WriteData_in,
  input  logic [2:0]        Funct3_in,
  input  logic [1:0]        ResultSrc_in,
  input  logic              MemWrite_in,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_we,
  output logic [ADDR_W-1:0] req_addr,
  output logic [31:0]       req_wdata,
  output logic [3:0]        req_be,
  input  logic              rsp_valid,
  input  logic [31:0]       rsp_rdata,
  output logic [31:0]       ReadData_out,
  output logic              Stall_out,
  output logic              Misaligned_out,
`ifdef MEM_LSU_TIMEOUT_EN
  output logic              Timeout_out,
`endif
  output logic [1:0]        dbg_state_o
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("mem_lsu: TIMEOUT_CYCLES must be in 1..65535");
  end

  // Bus handshake: a request transfers on a rising edge where req_valid and
  // req_ready are both high; req_* stay stable while req_valid waits on ready.
  // rsp_valid has no back-pressure and is only honoured in WAIT_RSP.

  lsu_state_e        state_q, state_d;
  logic              req_we_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [31:0]       req_wdata_q, rdata_q, ld_data;
  logic [3:0]        req_be_q, be_c;
  logic [31:0]       wdata_c;
  logic [2:0]        ld_f3_q;
  logic [1:0]        ld_lo_q;
  logic              mis_q, mis_c, access, start, tmo_hit, tmo_fire;

  assign access = MemWrite_in | (ResultSrc_in == RESULTSRC_LOAD);
  assign start  = (state_q == IDLE) && access && !mis_c;

  lsu_align u_align (
    .st_funct3_i  (Funct3_in),
    .st_addr_lo_i (ALUResult_in[1:0]),
    .st_wdata_i   (WriteData_in),
    .ld_funct3_i  (ld_f3_q),
    .ld_addr_lo_i (ld_lo_q),
    .ld_rdata_i   (rsp_rdata),
    .be_o         (be_c),
    .wdata_o      (wdata_c),
    .misaligned_o (mis_c),
    .ld_data_o    (ld_data)
  );

`ifdef MEM_LSU_TIMEOUT_EN
  logic [15:0] cnt_q;

  // cnt_q counts completed cycles in the current state, so the limit is
  // reached during the TIMEOUT_CYCLES-th cycle spent waiting.
  assign tmo_hit = ((state_q == REQ) || (state_q == WAIT_RSP)) &&
                   (cnt_q == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if ((state_d != state_q) || !((state_q == REQ) || (state_q == WAIT_RSP))) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign Timeout_out = tmo_fire;
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    Stall_out = 1'b0;
    tmo_fire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = REQ;
          Stall_out = 1'b1;
        end
      end
      REQ: begin
        Stall_out = 1'b1;
        if (req_ready) begin
          state_d = req_we_q ? DONE : WAIT_RSP;
        end else if (tmo_hit) begin
          state_d  = DONE;
          tmo_fire = 1'b1;
        end
      end
      WAIT_RSP: begin
        Stall_out = 1'b1;
        if (rsp_valid) begin
          state_d = DONE;
        end else if (tmo_hit) begin
          state_d  = DONE;
          tmo_fire = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_be_q    <= '0;
      ld_f3_q     <= F3_W;
      ld_lo_q     <= '0;
      rdata_q     <= '0;
      mis_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      mis_q   <= (state_q == IDLE) && access && mis_c;
      if (start) begin
        req_we_q    <= MemWrite_in;
        req_addr_q  <= {ALUResult_in[ADDR_W-1:2], 2'b00};
        req_wdata_q <= wdata_c;
        req_be_q    <= be_c;
        ld_f3_q     <= Funct3_in;
        ld_lo_q     <= ALUResult_in[1:0];
      end
      if (tmo_fire) begin
        rdata_q <= '0;
      end else if ((state_q == WAIT_RSP) && rsp_valid) begin
        rdata_q <= ld_data;
      end
    end
  end

  assign req_valid      = (state_q == REQ);
  assign req_we         = req_we_q;
  assign req_addr       = req_addr_q;
  assign req_wdata      = req_wdata_q;
  assign req_be         = req_be_q;
  assign ReadData_out   = rdata_q;
  assign Misaligned_out = mis_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed vector table, hand sequences and randomized accesses.
module tb_mem_lsu;

`ifdef MEM_LSU_TIMEOUT_EN
  localparam int TB_TMO = 8;
`else
  localparam int TB_TMO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] ALUResult_in = '0, WriteData_in = '0, rsp_rdata = '0;
  logic [2:0]  Funct3_in = '0;
  logic [1:0]  ResultSrc_in = '0;
  logic        MemWrite_in = 1'b0, req_ready = 1'b0, rsp_valid = 1'b0;
  logic        req_valid, req_we, Stall_out, Misaligned_out;
  logic [31:0] req_addr, req_wdata, ReadData_out;
  logic [3:0]  req_be;
  logic [1:0]  dbg_state_o;
`ifdef MEM_LSU_TIMEOUT_EN
  logic        Timeout_out;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  mem_lsu #(.ADDR_W(32), .TIMEOUT_CYCLES(TB_TMO)) dut (
    .clk(clk), .rst(rst),
    .ALUResult_in(ALUResult_in), .WriteData_in(WriteData_in), .Funct3_in(Funct3_in),
    .ResultSrc_in(ResultSrc_in), .MemWrite_in(MemWrite_in),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .ReadData_out(ReadData_out), .Stall_out(Stall_out), .Misaligned_out(Misaligned_out),
`ifdef MEM_LSU_TIMEOUT_EN
    .Timeout_out(Timeout_out),
`endif
    .dbg_state_o(dbg_state_o)
  );

  // clock
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, rdata;
    int          rdly, sdly;
    logic        exp_mis;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata, exp_rd;
    int          exp_stall;
  } vec_t;

  typedef struct {
    int          stall, req, mis;
    logic        we, unstable, hung;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  be;
  } res_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    MemWrite_in  = 1'b0;
    ResultSrc_in = 2'b00;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
  endtask

  // Present one instruction in EX/MEM and act as the memory until it retires.
  task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int rdly, input int sdly, output res_t r);
    int   req_idx, acc_cyc;
    logic accepted, started, fin;
    r.stall = 0; r.req = 0; r.mis = 0; r.we = 1'b0; r.unstable = 1'b0; r.hung = 1'b0;
    r.addr = '0; r.wdata = '0; r.rdata = '0; r.be = '0;
    req_idx = 0; acc_cyc = 0; accepted = 1'b0; started = 1'b0; fin = 1'b0;
    @(negedge clk);
    ALUResult_in = addr; WriteData_in = wdata; Funct3_in = f3; rsp_rdata = rdata;
    MemWrite_in  = we;   ResultSrc_in = we ? 2'b00 : 2'b01;
    req_ready = 1'b0; rsp_valid = 1'b0;
    for (int cyc = 0; cyc < 60 && !fin; cyc++) begin
      if (cyc > 0) @(negedge clk);
      #1;
      if (Stall_out) r.stall++;
      if (Misaligned_out) r.mis++;
      rsp_valid = 1'b0;
      if (req_valid) begin
        if (r.req == 0) begin
          r.we = req_we; r.addr = req_addr; r.wdata = req_wdata; r.be = req_be;
        end else if (req_we !== r.we || req_addr !== r.addr || req_wdata !== r.wdata || req_be !== r.be) begin
          r.unstable = 1'b1;
        end
        r.req++;
        req_ready = (req_idx >= rdly);
        if (req_ready) begin
          accepted = 1'b1;
          acc_cyc  = cyc;
        end
        req_idx++;
      end else begin
        req_ready = 1'b0;
      end
      if (accepted && !we && cyc == acc_cyc + sdly) rsp_valid = 1'b1;
      if (Stall_out) begin
        started = 1'b1;
      end else begin
        r.rdata = ReadData_out;
        fin = 1'b1;
      end
    end
    if (!fin) r.hung = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      idle_inputs();
      #1;
      if (Misaligned_out) r.mis++;
    end
  endtask

  task automatic check_result(input string tag, input res_t r, input logic we, input logic mis,
                              input logic [31:0] e_addr, input logic [3:0] e_be,
                              input logic [31:0] e_wdata, input logic [31:0] e_rd, input int e_stall);
    check({tag, " hung"}, 32'(r.hung), 32'd0);
    check({tag, " stall_cycles"}, 32'(r.stall), 32'(e_stall));
    check({tag, " misaligned_pulses"}, 32'(r.mis), mis ? 32'd1 : 32'd0);
    check({tag, " ReadData_out"}, r.rdata, e_rd);
    if (mis) begin
      check({tag, " req_valid_cycles"}, 32'(r.req), 32'd0);
    end else begin
      check({tag, " req_addr"}, r.addr, e_addr);
      check({tag, " req_we"}, 32'(r.we), 32'(we));
      check({tag, " req_stable"}, 32'(r.unstable), 32'd0);
      if (we) begin
        check({tag, " req_be"}, 32'(r.be), 32'(e_be));
        check({tag, " req_wdata"}, r.wdata, e_wdata);
      end
    end
  endtask

  // Reference model: byte/half/word arithmetic on lane offset and access size.
  function automatic void ref_model(input logic [2:0] f3, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic [31:0] rdata,
                                    output logic mis, output logic [3:0] be,
                                    output logic [31:0] wrep, output logic [31:0] rd);
    int          size, off;
    logic [31:0] mask, v;
    off  = int'(addr % 4);
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    mis  = (off % size) != 0;
    be   = 4'(((1 << size) - 1) << off);
    if (size == 1)      wrep = {24'b0, wdata[7:0]} * 32'h0101_0101;
    else if (size == 2) wrep = {16'b0, wdata[15:0]} * 32'h0001_0001;
    else                wrep = wdata;
    mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
    v    = (rdata >> (8 * off)) & mask;
    if (!f3[2] && size < 4 && v[8 * size - 1]) v = v | ~mask;
    rd = v;
  endfunction

  vec_t vecs[10];
  res_t r;

  initial begin
    // reset
    idle_inputs();
    rst = 1'b0;
    #12;
    check("rst state", 32'(dbg_state_o), 32'd0);
    check("rst req_valid", 32'(req_valid), 32'd0);
    check("rst req_we", 32'(req_we), 32'd0);
    check("rst req_addr", req_addr, 32'd0);
    check("rst req_wdata", req_wdata, 32'd0);
    check("rst req_be", 32'(req_be), 32'd0);
    check("rst ReadData_out", ReadData_out, 32'd0);
    check("rst Misaligned_out", 32'(Misaligned_out), 32'd0);
    check("rst Stall_out", 32'(Stall_out), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // directed vectors: we f3 addr wdata rdata rdly sdly | mis addr be wdata rd stall
    vecs[0] = '{1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        0, 1, 1'b0, 32'h100, 4'b1111, 32'hDEADBEEF, 32'h00000000, 2};
    vecs[1] = '{1'b0, 3'b000, 32'h103, 32'h0,        32'h80FF0102, 0, 1, 1'b0, 32'h100, 4'b0000, 32'h0,        32'hFFFFFF80, 3};
    vecs[2] = '{1'b0, 3'b101, 32'h202, 32'h0,        32'hBEEF1234, 4, 1, 1'b0, 32'h200, 4'b0000, 32'h0,        32'h0000BEEF, 7};
    vecs[3] = '{1'b1, 3'b001, 32'h301, 32'h1234,     32'h0,        0, 1, 1'b1, 32'h0,   4'b0000, 32'h0,        32'h0000BEEF, 0};
    vecs[4] = '{1'b1, 3'b000, 32'h003, 32'h000000A5, 32'h0,        0, 1, 1'b0, 32'h0,   4'b1000, 32'hA5A5A5A5, 32'h0000BEEF, 2};
    vecs[5] = '{1'b0, 3'b001, 32'h002, 32'h0,        32'h80010000, 0, 1, 1'b0, 32'h0,   4'b0000, 32'h0,        32'hFFFF8001, 3};
    vecs[6] = '{1'b0, 3'b010, 32'h004, 32'h0,        32'h12345678, 2, 3, 1'b0, 32'h4,   4'b0000, 32'h0,        32'h12345678, 7};
    vecs[7] = '{1'b0, 3'b010, 32'h006, 32'h0,        32'h0,        0, 1, 1'b1, 32'h0,   4'b0000, 32'h0,        32'h12345678, 0};
    vecs[8] = '{1'b1, 3'b001, 32'h012, 32'h0000CAFE, 32'h0,        1, 1, 1'b0, 32'h10,  4'b1100, 32'hCAFECAFE, 32'h12345678, 3};
    vecs[9] = '{1'b0, 3'b100, 32'h001, 32'h0,        32'h00008000, 0, 2, 1'b0, 32'h0,   4'b0000, 32'h0,        32'h00000080, 4};
    foreach (vecs[i]) begin
      do_access(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].rdata,
                vecs[i].rdly, vecs[i].sdly, r);
      check_result($sformatf("vec%0d", i), r, vecs[i].we, vecs[i].exp_mis, vecs[i].exp_addr,
                   vecs[i].exp_be, vecs[i].exp_wdata, vecs[i].exp_rd, vecs[i].exp_stall);
    end

    // reset while waiting for a load response, then a stray response
    begin
      logic seen;
      seen = 1'b0;
      @(negedge clk);
      ALUResult_in = 32'h40; Funct3_in = 3'b010; MemWrite_in = 1'b0; ResultSrc_in = 2'b01;
      req_ready = 1'b1;
      for (int k = 0; k < 10 && !seen; k++) begin
        @(negedge clk);
        #1;
        if (dbg_state_o == 2'd2) seen = 1'b1;
      end
      check("midrst reached WAIT_RSP", 32'(seen), 32'd1);
      rst = 1'b0;
      idle_inputs();
      #1;
      check("midrst req_valid", 32'(req_valid), 32'd0);
      check("midrst state", 32'(dbg_state_o), 32'd0);
      check("midrst ReadData_out", ReadData_out, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      rsp_valid = 1'b1; rsp_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      rsp_valid = 1'b0;
      #1;
      check("stray rsp ReadData_out", ReadData_out, 32'd0);
      check("stray rsp state", 32'(dbg_state_o), 32'd0);
      check("stray rsp Stall_out", 32'(Stall_out), 32'd0);
    end

    // randomized accesses against the reference model
    begin
      logic [2:0]  ld_f3s[5];
      logic        we, mis;
      logic [2:0]  f3;
      logic [31:0] addr, wdata, rdata, wrep, rd, last_rd, exp_rd;
      logic [3:0]  be;
      int          rdly, sdly, e_stall;
      ld_f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      last_rd = 32'd0;
      for (int i = 0; i < 40; i++) begin
        we    = 1'($urandom_range(0, 1));
        f3    = we ? 3'($urandom_range(0, 2)) : ld_f3s[$urandom_range(0, 4)];
        addr  = $urandom & 32'h0000_FFFF;
        wdata = $urandom;
        rdata = $urandom;
        rdly  = $urandom_range(0, 3);
        sdly  = $urandom_range(1, 3);
        ref_model(f3, addr, wdata, rdata, mis, be, wrep, rd);
        if (!mis && !we) last_rd = rd;
        exp_q.push_back(last_rd);
        e_stall = mis ? 0 : 2 + rdly + (we ? 0 : sdly);
        do_access(we, f3, addr, wdata, rdata, rdly, sdly, r);
        exp_rd = exp_q.pop_front();
        check_result($sformatf("rnd%0d", i), r, we, mis, {addr[31:2], 2'b00}, be, wrep,
                     exp_rd, e_stall);
      end
    end

`ifdef MEM_LSU_TIMEOUT_EN
    // watchdog: load whose request is never accepted
    begin
      int   req_cycles, tmo_at, tmo_cnt;
      logic done_seen;
      do_access(1'b0, 3'b010, 32'h80, 32'h0, 32'h5A5A5A5A, 0, 1, r);
      check("tmo preload ReadData_out", r.rdata, 32'h5A5A5A5A);
      req_cycles = 0; tmo_at = 0; tmo_cnt = 0; done_seen = 1'b0;
      @(negedge clk);
      ALUResult_in = 32'h84; Funct3_in = 3'b010; MemWrite_in = 1'b0; ResultSrc_in = 2'b01;
      req_ready = 1'b0;
      for (int k = 0; k < 40 && !done_seen; k++) begin
        if (k > 0) @(negedge clk);
        #1;
        if (dbg_state_o == 2'd1) req_cycles++;
        if (Timeout_out) begin
          tmo_cnt++;
          tmo_at = req_cycles;
        end
        if (dbg_state_o == 2'd3) begin
          done_seen = 1'b1;
          check("tmo DONE Stall_out", 32'(Stall_out), 32'd0);
          check("tmo DONE req_valid", 32'(req_valid), 32'd0);
          check("tmo ReadData_out", ReadData_out, 32'd0);
        end
      end
      check("tmo reached DONE", 32'(done_seen), 32'd1);
      check("tmo pulse count", 32'(tmo_cnt), 32'd1);
      check("tmo pulse REQ cycle", 32'(tmo_at), 32'd8);
      @(negedge clk);
      idle_inputs();
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- MEM-stage load/store unit on the consumer side of the EX/MEM pipeline register.
- Takes address, store data and control from EX/MEM and runs one transaction per memory instruction on a valid/ready data-memory bus.
- Returns aligned, extended load data toward MEM/WB.
- Asserts a stall that holds EX/MEM and all earlier pipeline registers until the access completes.

Parameters:
- ADDR_W, 32, bus address width.
- TIMEOUT_CYCLES, 255, watchdog limit. Used only when MEM_LSU_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- ALUResult_in  in  32  effective address.
- WriteData_in  in  32  store data, unaligned.
- Funct3_in  in  3  access size and sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- ResultSrc_in  in  2  value 01 means load.
- MemWrite_in  in  1  store.
- req_valid  out  1  bus request valid.
- req_ready  in  1  bus accepts the request.
- req_we  out  1  1 = write.
- req_addr  out  ADDR_W  word-aligned address, {addr[ADDR_W-1:2], 2'b00}.
- req_wdata  out  32  lane-replicated store data.
- req_be  out  4  byte enables.
- rsp_valid  in  1  read data valid.
- rsp_rdata  in  32  read data word.
- ReadData_out  out  32  extended load result.
- Stall_out  out  1  drives en=0 on EX/MEM and earlier registers.
- Misaligned_out  out  1  one-cycle pulse for a rejected misaligned access.

Behaviour:
- Access: access = MemWrite_in | (ResultSrc_in==01). MemWrite takes priority if both are set.
- FSM states: IDLE, REQ, WAIT_RSP, DONE.
- IDLE
  - Aligned access → REQ.
  - Misaligned access (h with addr[0]=1, w with addr[1:0]≠0) → Misaligned_out=1 for one cycle, no bus request, no stall, remain in IDLE.
- REQ
  - req_valid=1. Address, data, we and be are registered on entry and held stable until req_ready.
  - On req_valid & req_ready: a store goes to DONE (posted write); a load goes to WAIT_RSP.
- WAIT_RSP
  - On rsp_valid: capture rsp_rdata, extract the lane by addr[1:0] and size, sign- or zero-extend, then → DONE.
  - rsp_valid seen in any other state is ignored.
- DONE
  - Stall_out=0 for exactly this cycle so the pipeline advances; → IDLE.
  - The access is never re-issued while the same instruction sits in EX/MEM.
- Stall_out is combinational:
  - 1 when in IDLE with an aligned access present;
  - 1 in REQ and in WAIT_RSP;
  - 0 in DONE.
- ReadData_out is registered. It updates only on load capture and holds its value otherwise.
- Byte enables:
  - b → 0001<<addr[1:0], wdata = {4{byte}}.
  - h → 0011<<addr[1:0], wdata = {2{half}}.
  - w → 1111.
- Minimum latency:
  - store with req_ready already high: 2 cycles of stall;
  - load with rsp_valid one cycle after accept: 3 cycles of stall.
- Reset: state=IDLE; req_valid=0, req_we=0, req_addr=0, req_wdata=0, req_be=0, ReadData_out=0, Misaligned_out=0. Stall_out follows the IDLE rule.
- Reset in the middle of a transaction abandons it immediately. A later stray rsp_valid is ignored.

Optional Feature:
- Macro: MEM_LSU_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter runs in REQ and WAIT_RSP and clears on every state change.
  - When the count reaches TIMEOUT_CYCLES: drop req_valid, set ReadData_out=0, pulse extra output Timeout_out for one cycle, → DONE.
- Undefined: no counter and no Timeout_out port; the FSM waits indefinitely.

Decomposition:
- lsu_pkg holds:
  - state enum (IDLE=0, REQ=1, WAIT_RSP=2, DONE=3);
  - Funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - RESULTSRC_LOAD=2'b01.
- Sub-module lsu_align (combinational) produces req_be, replicated wdata, the misaligned flag and the extended load data. mem_lsu contains the FSM, registers and watchdog.

Test Plan:
- sw, addr 0x100, data 0xDEADBEEF, req_ready=1 → req_be=1111, req_addr=0x100, Stall_out high 2 cycles, no ReadData_out change.
- lb, addr 0x103, rsp_rdata 0x80FF0102 one cycle after accept → ReadData_out=0xFFFFFF80, Stall_out high 3 cycles.
- lhu, addr 0x202, rsp_rdata 0xBEEF1234, req_ready delayed 4 cycles → req fields stable throughout, ReadData_out=0x0000BEEF.
- sh, addr 0x301 → Misaligned_out pulse, req_valid never asserted, Stall_out=0.
- rst low while in WAIT_RSP, then rsp_valid → req_valid=0, state IDLE, ReadData_out=0, response ignored.
- MEM_LSU_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, lw with req_ready held 0 → Timeout_out pulse after 8 cycles in REQ, ReadData_out=0, pipeline released.
